// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet datapath, controller and state bank:
// sizing helpers, activation zero test and negative clamp.
package maxnet_pkg;

  localparam int N_DEF = 6;
  localparam int W_DEF = 32;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STREAM,
    RD_LAST
  } rd_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Float mode ignores the sign bit so -0.0 counts as inactive.
  function automatic logic is_zero(input logic [MAX_W-1:0] v, input int w, input logic flt);
    logic z;
    z = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w - 1) || ((i == w - 1) && !flt)) begin
        if (v[i]) z = 1'b0;
      end
    end
    return z;
  endfunction

  function automatic logic [MAX_W-1:0] clamp(input logic [MAX_W-1:0] v, input int w,
                                             input logic clamp_neg);
    if (clamp_neg && v[w-1]) return '0;
    return v;
  endfunction

endpackage

// File: rtl/maxnet_active_tracker.sv
// Popcount and lowest-index priority encoder over the neuron active mask.
module maxnet_active_tracker
  import maxnet_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int AW = (clog2(N) > 1) ? clog2(N) : 1,
  localparam int CW = clog2(N + 1)
) (
  input  logic [N-1:0]  active_mask,
  output logic [CW-1:0] active_cnt,
  output logic          winner_valid,
  output logic [AW-1:0] winner_idx
);

  // Walking downward lets the lowest set bit win the encoder.
  always_comb begin
    active_cnt = '0;
    winner_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      active_cnt = active_cnt + CW'(active_mask[i]);
      if (active_mask[i]) winner_idx = AW'(i);
    end
  end

  assign winner_valid = (active_cnt == CW'(1));

endmodule

// File: rtl/maxnet_state_bank.sv
// Activation register bank for the Maxnet loop: parallel/single writes with
// ReLU clamp, live winner tracking, serial readback and iteration counting.
module maxnet_state_bank
  import maxnet_pkg::*;
#(
  parameter int   N         = N_DEF,
  parameter int   W         = W_DEF,
  parameter logic FLOAT     = 1'b1,
  parameter logic CLAMP_NEG = 1'b1,
  parameter int   ITW       = 16,
  localparam int  AW        = (clog2(N) > 1) ? clog2(N) : 1,
  localparam int  CW        = clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [N*W-1:0] d_flat,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  output logic [N*W-1:0] q_flat,
  output logic [N-1:0]   active_mask,
  output logic [CW-1:0]  active_cnt,
  output logic           winner_valid,
  output logic [AW-1:0]  winner_idx,
  input  logic           rd_req,
  output logic           rd_busy,
  output logic           rd_valid,
  output logic [AW-1:0]  rd_idx,
  output logic [W-1:0]   rd_data,
  output logic           rd_last,
  output logic [ITW-1:0] iter_cnt
);

  rd_state_t     state;
  rd_state_t     state_nxt;
  logic [AW-1:0] ptr;
  logic [W-1:0]  sel_data;
  logic          ptr_end;

  function automatic logic [W-1:0] clamp_w(input logic [W-1:0] v);
    logic [MAX_W-1:0] t;
    t = clamp(MAX_W'(v), W, CLAMP_NEG);
    return t[W-1:0];
  endfunction

  // Storage: clr > load > wr_en; out-of-range wr_addr matches no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flat   <= '0;
      iter_cnt <= '0;
    end else if (clr) begin
      q_flat   <= '0;
      iter_cnt <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) q_flat[i*W +: W] <= clamp_w(d_flat[i*W +: W]);
      iter_cnt <= iter_cnt + ITW'(1);
    end else if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (wr_addr == AW'(i)) q_flat[i*W +: W] <= clamp_w(wr_data);
      end
    end
  end

  always_comb begin
    active_mask = '0;
    for (int i = 0; i < N; i++) active_mask[i] = !is_zero(MAX_W'(q_flat[i*W +: W]), W, FLOAT);
  end

  maxnet_active_tracker #(.N(N)) u_tracker (
    .active_mask  (active_mask),
    .active_cnt   (active_cnt),
    .winner_valid (winner_valid),
    .winner_idx   (winner_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr == AW'(i)) sel_data = q_flat[i*W +: W];
    end
  end

  assign ptr_end = (ptr == AW'(N - 1));
  assign rd_busy = (state != RD_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:   if (rd_req && !clr) state_nxt = RD_STREAM;
      RD_STREAM: begin
        if (clr)          state_nxt = RD_IDLE;
        else if (ptr_end) state_nxt = RD_LAST;
      end
      RD_LAST:   state_nxt = RD_IDLE;
      default:   state_nxt = RD_IDLE;
    endcase
  end

  // Readback beat: registered one cycle behind ptr, sampling live storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      ptr      <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_idx   <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        ptr      <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else if (state == RD_STREAM) begin
        rd_valid <= 1'b1;
        rd_idx   <= ptr;
        rd_data  <= sel_data;
        rd_last  <= ptr_end;
        if (!ptr_end) ptr <= ptr + AW'(1);
      end else begin
        ptr      <= '0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/maxnet_state_bank.md
Name: maxnet_state_bank

Overview:
- Parametrised successor to the fixed six-entry float register bank. Holds N neuron activations of width W for the Maxnet iteration loop.
- Adds parallel and single-entry writes, negative-value clamping, and live active/winner tracking.
- Adds a serial readback stream and an iteration counter.
- Sits between the Maxnet datapath (which produces N updated activations per iteration) and the controller (which stops on winner_valid).

Parameters:
- N, 6, number of entries/neurons (N >= 2)
- W, 32, entry width in bits
- FLOAT, 1, 1: entries are IEEE-754 (sign = bit W-1, zero test ignores sign); 0: two's-complement integer
- CLAMP_NEG, 1, 1: any written value with sign bit set is stored as all-zeros (ReLU); 0: stored as-is
- ITW, 16, iteration counter width
- AW (derived), max(1, clog2(N)), index width
- CW (derived), clog2(N+1), count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of storage, iter_cnt and read FSM
- load  in  1  parallel load of all N entries
- d_flat  in  N*W  parallel data; entry i = d_flat[i*W +: W]
- wr_en  in  1  single-entry write
- wr_addr  in  AW  single-entry index
- wr_data  in  W  single-entry data
- q_flat  out  N*W  stored entries; entry i at [i*W +: W]
- active_mask  out  N  bit i = entry i nonzero
- active_cnt  out  CW  popcount of active_mask
- winner_valid  out  1  active_cnt == 1
- winner_idx  out  AW  index of lowest set active_mask bit (0 if none)
- rd_req  in  1  start a readback stream
- rd_busy  out  1  stream in progress
- rd_valid  out  1  rd_idx/rd_data valid this cycle
- rd_idx  out  AW  streamed index
- rd_data  out  W  streamed value
- rd_last  out  1  final beat (rd_idx == N-1)
- iter_cnt  out  ITW  number of accepted parallel loads since reset/clr

Behaviour:
- Reset (rst_n low, async): all storage 0, q_flat 0, active_mask 0, active_cnt 0, winner_valid 0, winner_idx 0, iter_cnt 0, read FSM IDLE, rd_busy/rd_valid/rd_last 0, rd_idx 0, rd_data 0. Reset mid-stream aborts the stream immediately.
- Storage is the q_flat register. Writes at edge k are visible on q_flat after edge k (one-cycle latency from input).
- Write priority per edge: clr > load > wr_en.
  - clr: storage and iter_cnt cleared; FSM to IDLE.
  - load: all N entries written; wr_en ignored that cycle; iter_cnt += 1, wrapping at 2^ITW.
  - wr_en: only entry wr_addr written. wr_addr >= N is ignored, no state change.
- Clamp: when CLAMP_NEG=1, a value with bit W-1 = 1 is stored as 0. This applies to both load and wr_en paths.
- Zero test:
  - FLOAT=1: value[W-2:0] == 0 (so -0.0 is inactive).
  - FLOAT=0: value == 0.
- active_mask, active_cnt, winner_valid and winner_idx are combinational from storage, with no extra latency beyond storage.
- Read FSM, IDLE / STREAM:
  - IDLE, rd_req=1, clr=0: go to STREAM and set ptr=0.
  - STREAM: each cycle rd_valid=1, rd_idx=ptr, rd_data=live storage[ptr] (registered output, one cycle after ptr update). ptr increments by 1 per cycle.
  - The beat with ptr==N-1 asserts rd_last; the FSM returns to IDLE on the following edge.
  - rd_busy=1 from the edge accepting rd_req through the edge after rd_last.
  - rd_req while busy is ignored (no queueing).
  - A stream lasts exactly N beats.
  - Writes during a stream are allowed. A beat reflects storage as it stands at that beat's edge.
  - clr mid-stream: rd_valid drops next cycle and the FSM goes to IDLE.
- Out-of-range ptr never occurs. ptr wraps only by return to IDLE.

Decomposition:
- Shared package (maxnet_pkg):
  - clog2 function
  - is_zero(value, FLOAT) and clamp(value, CLAMP_NEG) functions
  - default N/W constants, shared with the datapath
- One sub-module, maxnet_active_tracker: combinational popcount plus lowest-index priority encoder over active_mask, producing active_cnt, winner_valid and winner_idx. It is reused by the controller.

Test Plan:
- Reset/async: drive rst_n low mid-cycle with storage loaded -> q_flat, active_cnt, iter_cnt read 0 immediately, before the next clk edge.
- Parallel load, N=6, W=32, d = {1.0, 0.5, -0.25, 0, -0.0, 2.0}, CLAMP_NEG=1 -> entries {3F800000, 3F000000, 0, 0, 0, 40000000}, active_mask=6'b100011, active_cnt=3, winner_valid=0, iter_cnt=1.
- Single writes: zero entries 0 and 1 via wr_en -> active_cnt=1, winner_valid=1, winner_idx=5. Then write wr_addr=7 -> no change.
- Priority: assert load and wr_en (addr 2, 3F800000) together -> only load data stored, iter_cnt += 1. Assert clr together with load -> all zero, iter_cnt=0.
- Readback: rd_req one cycle -> exactly 6 beats, rd_idx 0..5, rd_last only on idx 5, rd_busy deasserted after. A second rd_req mid-stream is ignored. wr_en to entry 4 during beat 2 -> beat 4 shows the new value.
- Wrap: ITW=4, 17 loads -> iter_cnt=1. clr during stream beat 3 -> rd_valid=0 next cycle, FSM IDLE.
